// File: rtl/nec_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | nec_pkg : shared types and constants for the NEC IR receiver     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package nec_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LEAD_MARK  = 3'd1,
        S_LEAD_SPACE = 3'd2,
        S_BIT_MARK   = 3'd3,
        S_BIT_SPACE  = 3'd4,
        S_STOP_MARK  = 3'd5
    } nec_state_e;

    localparam logic [1:0] C_ERR_NONE    = 2'b00;
    localparam logic [1:0] C_ERR_TIMING  = 2'b01;
    localparam logic [1:0] C_ERR_INVERSE = 2'b10;
    localparam logic [1:0] C_ERR_TIMEOUT = 2'b11;

    localparam int C_LEAD_MARK_US    = 9000;
    localparam int C_LEAD_SPACE_US   = 4500;
    localparam int C_REPEAT_SPACE_US = 2250;
    localparam int C_BIT_MARK_US     = 562;
    localparam int C_ONE_SPACE_US    = 1687;

    // Window edge in ticks for a nominal duration scaled by pct/100, truncated.
    function automatic int win_ticks(input int nom_us, input int freq_mhz, input int pct);
        return (nom_us * freq_mhz * pct) / 100;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nec_in_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | nec_in_conditioner : 2-flop synchroniser, optional glitch filter |
// | (NEC_RX_GLITCH_FILTER_EN) and rise/fall strobes.    Rev 1.0      |
// +------------------------------------------------------------------+
module nec_in_conditioner #(
    parameter int GLITCH_TICKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_data,
    output logic o_rise,
    output logic o_fall
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic w_level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= i_data;
            sync2_q <= sync1_q;
            prev_q  <= w_level;
        end
    end

`ifdef NEC_RX_GLITCH_FILTER_EN
    localparam int CW = (GLITCH_TICKS > 1) ? $clog2(GLITCH_TICKS) : 1;

    logic [CW-1:0] run_q;
    logic [CW-1:0] run_d;
    logic          filt_q;
    logic          filt_d;

    // The filtered level follows only after GLITCH_TICKS consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        run_d  = '0;
        if (sync2_q != filt_q) begin
            if (run_q == CW'(GLITCH_TICKS - 1)) begin
                filt_d = sync2_q;
            end else begin
                run_d = run_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            run_q  <= '0;
        end else begin
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end

    assign w_level = filt_q;
`else
    localparam int C_UNUSED_GLITCH = GLITCH_TICKS;
    assign w_level = sync2_q;
`endif

    assign o_rise = w_level & ~prev_q;
    assign o_fall = ~w_level & prev_q;

endmodule
`default_nettype wire

// File: rtl/nec_ir_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | nec_ir_decoder : NEC IR frame / repeat-code decoder.             |
// | Optional glitch filter: NEC_RX_GLITCH_FILTER_EN.     Rev 1.0     |
// +------------------------------------------------------------------+
module nec_ir_decoder
    import nec_pkg::*;
#(
    parameter int FREQ_MHz     = 1,
    parameter int TOL_PCT      = 20,
    parameter int TIMEOUT_US   = 12000,
    parameter int GLITCH_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_data,
    input  logic        i_ext_mode,
    output logic [15:0] o_address,
    output logic [7:0]  o_command,
    output logic        o_valid,
    output logic        o_repeat,
    output logic        o_error,
    output logic [1:0]  o_err_code
);

    localparam int CW = $clog2(TIMEOUT_US * FREQ_MHz + 1);
    localparam int LO = 100 - TOL_PCT;
    localparam int HI = 100 + TOL_PCT;

    localparam logic [CW-1:0] C_TMO   = CW'(TIMEOUT_US * FREQ_MHz);
    localparam logic [CW-1:0] C_LM_LO = CW'(win_ticks(C_LEAD_MARK_US, FREQ_MHz, LO));
    localparam logic [CW-1:0] C_LM_HI = CW'(win_ticks(C_LEAD_MARK_US, FREQ_MHz, HI));
    localparam logic [CW-1:0] C_LS_LO = CW'(win_ticks(C_LEAD_SPACE_US, FREQ_MHz, LO));
    localparam logic [CW-1:0] C_LS_HI = CW'(win_ticks(C_LEAD_SPACE_US, FREQ_MHz, HI));
    localparam logic [CW-1:0] C_RS_LO = CW'(win_ticks(C_REPEAT_SPACE_US, FREQ_MHz, LO));
    localparam logic [CW-1:0] C_RS_HI = CW'(win_ticks(C_REPEAT_SPACE_US, FREQ_MHz, HI));
    localparam logic [CW-1:0] C_BM_LO = CW'(win_ticks(C_BIT_MARK_US, FREQ_MHz, LO));
    localparam logic [CW-1:0] C_BM_HI = CW'(win_ticks(C_BIT_MARK_US, FREQ_MHz, HI));
    localparam logic [CW-1:0] C_OS_LO = CW'(win_ticks(C_ONE_SPACE_US, FREQ_MHz, LO));
    localparam logic [CW-1:0] C_OS_HI = CW'(win_ticks(C_ONE_SPACE_US, FREQ_MHz, HI));

    function automatic logic in_win(input logic [CW-1:0] c, input logic [CW-1:0] lo,
                                    input logic [CW-1:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

    logic w_rise;
    logic w_fall;

    nec_in_conditioner #(
        .GLITCH_TICKS (GLITCH_TICKS)
    ) u_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (i_data),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    nec_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   shift_q, shift_d;
    logic [4:0]    idx_q, idx_d;
    logic          rpt_q, rpt_d;
    logic          seen_q, seen_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          valid_q, valid_d;
    logic          repeat_q, repeat_d;
    logic          error_q, error_d;
    logic [1:0]    err_code_q, err_code_d;

    // Shift register holds bytes in arrival order: addr, addr_bar, cmd, cmd_bar.
    logic [7:0] w_addr, w_addr_n, w_cmd, w_cmd_n;
    assign w_addr   = shift_q[7:0];
    assign w_addr_n = shift_q[15:8];
    assign w_cmd    = shift_q[23:16];
    assign w_cmd_n  = shift_q[31:24];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            idx_q      <= '0;
            rpt_q      <= 1'b0;
            seen_q     <= 1'b0;
            addr_q     <= '0;
            cmd_q      <= '0;
            valid_q    <= 1'b0;
            repeat_q   <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= C_ERR_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            rpt_q      <= rpt_d;
            seen_q     <= seen_d;
            addr_q     <= addr_d;
            cmd_q      <= cmd_d;
            valid_q    <= valid_d;
            repeat_q   <= repeat_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        rpt_d      = rpt_q;
        seen_d     = seen_q;
        addr_d     = addr_q;
        cmd_d      = cmd_q;
        valid_d    = 1'b0;
        repeat_d   = 1'b0;
        error_d    = 1'b0;
        err_code_d = err_code_q;

        if (w_rise || w_fall) begin
            cnt_d = '0;
        end else if (cnt_q != C_TMO) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Timeout is evaluated first so it overrides a coincident edge.
        if (state_q != S_IDLE && cnt_q == C_TMO) begin
            error_d    = 1'b1;
            err_code_d = C_ERR_TIMEOUT;
            state_d    = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (w_fall) begin
                        state_d = S_LEAD_MARK;
                        rpt_d   = 1'b0;
                    end
                end
                S_LEAD_MARK: begin
                    if (w_rise) begin
                        if (in_win(cnt_q, C_LM_LO, C_LM_HI)) begin
                            state_d = S_LEAD_SPACE;
                        end else begin
                            error_d    = 1'b1;
                            err_code_d = C_ERR_TIMING;
                            state_d    = S_IDLE;
                        end
                    end
                end
                S_LEAD_SPACE: begin
                    if (w_fall) begin
                        if (in_win(cnt_q, C_LS_LO, C_LS_HI)) begin
                            state_d = S_BIT_MARK;
                            idx_d   = '0;
                            shift_d = '0;
                        end else if (in_win(cnt_q, C_RS_LO, C_RS_HI)) begin
                            state_d = S_STOP_MARK;
                            rpt_d   = 1'b1;
                        end else begin
                            error_d    = 1'b1;
                            err_code_d = C_ERR_TIMING;
                            state_d    = S_IDLE;
                        end
                    end
                end
                S_BIT_MARK: begin
                    if (w_rise) begin
                        if (in_win(cnt_q, C_BM_LO, C_BM_HI)) begin
                            state_d = S_BIT_SPACE;
                        end else begin
                            error_d    = 1'b1;
                            err_code_d = C_ERR_TIMING;
                            state_d    = S_IDLE;
                        end
                    end
                end
                S_BIT_SPACE: begin
                    if (w_fall) begin
                        if (in_win(cnt_q, C_BM_LO, C_BM_HI) || in_win(cnt_q, C_OS_LO, C_OS_HI)) begin
                            shift_d = {in_win(cnt_q, C_OS_LO, C_OS_HI), shift_q[31:1]};
                            idx_d   = idx_q + 5'd1;
                            state_d = (idx_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
                        end else begin
                            error_d    = 1'b1;
                            err_code_d = C_ERR_TIMING;
                            state_d    = S_IDLE;
                        end
                    end
                end
                S_STOP_MARK: begin
                    if (w_rise) begin
                        state_d = S_IDLE;
                        if (!in_win(cnt_q, C_BM_LO, C_BM_HI)) begin
                            error_d    = 1'b1;
                            err_code_d = C_ERR_TIMING;
                        end else if (rpt_q) begin
                            repeat_d = seen_q;
                        end else if ((w_cmd ^ w_cmd_n) != 8'hFF ||
                                     (!i_ext_mode && w_addr_n != ~w_addr)) begin
                            error_d    = 1'b1;
                            err_code_d = C_ERR_INVERSE;
                        end else begin
                            valid_d = 1'b1;
                            seen_d  = 1'b1;
                            addr_d  = i_ext_mode ? {w_addr_n, w_addr} : {8'h00, w_addr};
                            cmd_d   = w_cmd;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign o_address  = addr_q;
    assign o_command  = cmd_q;
    assign o_valid    = valid_q;
    assign o_repeat   = repeat_q;
    assign o_error    = error_q;
    assign o_err_code = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_nec_ir_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_nec_ir_decoder : directed + randomized bench with frame model |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_nec_ir_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_data;
    logic        i_ext_mode;
    logic [15:0] o_address;
    logic [7:0]  o_command;
    logic        o_valid;
    logic        o_repeat;
    logic        o_error;
    logic [1:0]  o_err_code;

    int checks = 0;
    int errors = 0;

    int          n_valid = 0, n_rep = 0, n_err = 0, n_excl = 0;
    logic [15:0] cap_addr = '0;
    logic [7:0]  cap_cmd  = '0;
    logic [1:0]  cap_code = '0;

    bit          m_seen = 1'b0;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_cmd  = '0;

    nec_ir_decoder #(
        .FREQ_MHz     (1),
        .TOL_PCT      (20),
        .TIMEOUT_US   (12000),
        .GLITCH_TICKS (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data     (i_data),
        .i_ext_mode (i_ext_mode),
        .o_address  (o_address),
        .o_command  (o_command),
        .o_valid    (o_valid),
        .o_repeat   (o_repeat),
        .o_error    (o_error),
        .o_err_code (o_err_code)
    );

    always #5 clk = ~clk;

    // Pulse recorder: counts pulses and captures outputs in the pulse cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid) begin
                n_valid++;
                cap_addr = o_address;
                cap_cmd  = o_command;
            end
            if (o_repeat) n_rep++;
            if (o_error) begin
                n_err++;
                cap_code = o_err_code;
            end
            if (int'(o_valid) + int'(o_repeat) + int'(o_error) > 1) n_excl++;
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        i_data = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_lead(input int mark_us, input int space_us);
        hold(1'b0, mark_us);
        hold(1'b1, space_us);
    endtask

    task automatic send_bits(input logic [31:0] w, input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            hold(1'b0, 562);
            hold(1'b1, w[i] ? 1687 : 562);
        end
    endtask

    // Reference: a byte and its complement always sum to 255.
    function automatic bit model_accept(input logic [31:0] w, input bit ext);
        int a  = int'(w[7:0]);
        int ab = int'(w[15:8]);
        int c  = int'(w[23:16]);
        int cb = int'(w[31:24]);
        return (c + cb == 255) && (ext || (a + ab == 255));
    endfunction

    function automatic logic [31:0] rand_frame(input bit force_ok);
        logic [7:0] a  = 8'($urandom);
        logic [7:0] c  = 8'($urandom);
        logic [7:0] ab = (force_ok || $urandom_range(0, 1) == 1) ? ~a : 8'($urandom);
        logic [7:0] cb = (force_ok || $urandom_range(0, 1) == 1) ? ~c : 8'($urandom);
        return {cb, c, ab, a};
    endfunction

    task automatic finish_frame_check(input string tag, input logic [31:0] w, input bit ext,
                                      input int v0, input int e0, input int r0);
        bit ok = model_accept(w, ext);
        if (ok) begin
            m_seen = 1'b1;
            m_addr = ext ? w[15:0] : {8'h00, w[7:0]};
            m_cmd  = w[23:16];
        end
        chk({tag, ".valid"}, n_valid - v0, ok ? 1 : 0);
        chk({tag, ".error"}, n_err - e0, ok ? 0 : 1);
        chk({tag, ".repeat"}, n_rep - r0, 0);
        if (ok) begin
            chk({tag, ".cap_addr"}, cap_addr, m_addr);
            chk({tag, ".cap_cmd"}, cap_cmd, m_cmd);
        end else begin
            chk({tag, ".code"}, cap_code, 2'b10);
        end
        chk({tag, ".addr"}, o_address, m_addr);
        chk({tag, ".cmd"}, o_command, m_cmd);
    endtask

    task automatic do_frame(input string tag, input logic [31:0] w, input bit ext);
        int v0 = n_valid;
        int e0 = n_err;
        int r0 = n_rep;
        i_ext_mode = ext;
        send_lead(9000, 4500);
        send_bits(w, 0, 32);
        hold(1'b0, 562);
        hold(1'b1, 40);
        finish_frame_check(tag, w, ext, v0, e0, r0);
    endtask

    task automatic do_repeat(input string tag);
        int v0 = n_valid;
        int e0 = n_err;
        int r0 = n_rep;
        send_lead(9000, 2250);
        hold(1'b0, 562);
        hold(1'b1, 40);
        chk({tag, ".repeat"}, n_rep - r0, m_seen ? 1 : 0);
        chk({tag, ".error"}, n_err - e0, 0);
        chk({tag, ".valid"}, n_valid - v0, 0);
        chk({tag, ".addr"}, o_address, m_addr);
    endtask

    initial begin
        logic [31:0] w;
        int v0, e0, r0;
        bit ext;

        rst_n      = 1'b0;
        i_data     = 1'b1;
        i_ext_mode = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst.addr", o_address, 16'h0);
        chk("rst.cmd", o_command, 8'h0);
        chk("rst.valid", o_valid, 1'b0);
        chk("rst.repeat", o_repeat, 1'b0);
        chk("rst.error", o_error, 1'b0);
        chk("rst.code", o_err_code, 2'b00);
        rst_n = 1'b1;
        hold(1'b1, 50);

        do_repeat("rpt_cold");
        do_frame("frame_2e", 32'hF20D_D12E, 1'b0);
        do_repeat("rpt_warm");
        do_frame("frame_ext", 32'hE619_1716, 1'b1);
        do_frame("frame_ext_as_std", 32'hE619_1716, 1'b0);

        v0 = n_valid; e0 = n_err;
        hold(1'b0, 6000);
        hold(1'b1, 40);
        chk("short_lead.error", n_err - e0, 1);
        chk("short_lead.code", cap_code, 2'b01);
        chk("short_lead.valid", n_valid - v0, 0);

        w = rand_frame(1'b0);
        v0 = n_valid; e0 = n_err;
        send_lead(9000, 4500);
        send_bits(w, 0, 10);
        hold(1'b0, 562);
        hold(1'b1, 13000);
        chk("timeout.error", n_err - e0, 1);
        chk("timeout.code", cap_code, 2'b11);
        chk("timeout.valid", n_valid - v0, 0);
        chk("timeout.addr", o_address, m_addr);
        do_frame("after_timeout", rand_frame(1'b1), 1'b0);

        w = rand_frame(1'b1);
        i_ext_mode = 1'b0;
        send_lead(9000, 4500);
        send_bits(w, 0, 16);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_seen = 1'b0; m_addr = '0; m_cmd = '0;
        chk("midrst.addr", o_address, 16'h0);
        chk("midrst.cmd", o_command, 8'h0);
        chk("midrst.code", o_err_code, 2'b00);
        chk("midrst.valid", o_valid, 1'b0);
        hold(1'b1, 100);
        do_repeat("rpt_after_rst");
        ext = ($urandom_range(0, 1) == 1);
        do_frame("post_rst", rand_frame(1'b0), ext);

`ifdef NEC_RX_GLITCH_FILTER_EN
        w = rand_frame(1'b1);
        w[0] = 1'b1;
        i_ext_mode = 1'b0;
        v0 = n_valid; e0 = n_err; r0 = n_rep;
        send_lead(9000, 4500);
        hold(1'b0, 562);
        hold(1'b1, 800);
        hold(1'b0, 2);
        hold(1'b1, 885);
        send_bits(w, 1, 31);
        hold(1'b0, 562);
        hold(1'b1, 40);
        finish_frame_check("glitch", w, 1'b0, v0, e0, r0);
`else
        v0 = n_valid; e0 = n_err;
        send_lead(9000, 4500);
        hold(1'b0, 562);
        hold(1'b1, 800);
        hold(1'b0, 2);
        hold(1'b1, 200);
        chk("glitch.error", n_err - e0, 1);
        chk("glitch.code", cap_code, 2'b01);
        chk("glitch.valid", n_valid - v0, 0);
`endif

        chk("exclusive", n_excl, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nec_ir_decoder.md
NEC_IR_DECODER -- requirements
Module: nec_ir_decoder

Interface
REQ-001 Parameter FREQ_MHz, default 1: clk ticks per microsecond; all durations scale as us*FREQ_MHz.
REQ-002 Parameter TOL_PCT, default 20: symmetric timing tolerance, percent of nominal.
REQ-003 Parameter TIMEOUT_US, default 12000: maximum duration of any single mark or space.
REQ-004 Parameter GLITCH_TICKS, default 4: filter length; used only with NEC_RX_GLITCH_FILTER_EN.
REQ-005 clk  in  1  system clock, single domain.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 i_data  in  1  IR demodulator output; idle high, mark low; asynchronous to clk.
REQ-008 i_ext_mode  in  1  1 = 16-bit extended address; 0 = 8-bit address plus inverse.
REQ-009 o_address  out  16  decoded address.
REQ-010 o_command  out  8  decoded command.
REQ-011 o_valid  out  1  one-cycle pulse, new frame accepted.
REQ-012 o_repeat  out  1  one-cycle pulse, repeat code accepted.
REQ-013 o_error  out  1  one-cycle pulse, frame rejected.
REQ-014 o_err_code  out  2  01 timing, 10 inverse-check fail, 11 timeout; held until next o_error.

Function
REQ-015 i_data passes through a 2-flop synchroniser; edges are detected on the synchronised signal.
REQ-016 A saturating tick counter clears on every accepted edge; its width is clog2(TIMEOUT_US*FREQ_MHz+1).
REQ-017 Window for nominal N us is [N*FREQ_MHz*(100-TOL_PCT)/100, N*FREQ_MHz*(100+TOL_PCT)/100], inclusive, integer-truncated localparams.
REQ-018 States: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK.
REQ-019 IDLE: falling edge -> LEAD_MARK.
REQ-020 LEAD_MARK: rising edge with count in 9000 window -> LEAD_SPACE; otherwise error 01 -> IDLE.
REQ-021 LEAD_SPACE: falling edge with count in 4500 window -> BIT_MARK, bit index 0; in 2250 window -> STOP_MARK with repeat flag set; otherwise error 01.
REQ-022 BIT_MARK: rising edge with count in 562 window -> BIT_SPACE; otherwise error 01.
REQ-023 BIT_SPACE: falling edge with count in 562 window shifts in 0, in 1687 window shifts in 1, otherwise error 01; LSB first into a 32-bit register; after bit 31 -> STOP_MARK, else -> BIT_MARK.
REQ-024 STOP_MARK: rising edge with count in 562 window completes the frame or repeat; otherwise error 01; always -> IDLE.
REQ-025 Any non-IDLE state whose count reaches the TIMEOUT_US limit -> error 11, IDLE; when timeout and an edge occur in the same cycle, timeout wins.
REQ-026 Frame completion with command^command_bar != 8'hFF -> error 10.
REQ-027 Frame completion with i_ext_mode=0 (sampled at completion) and address_bar != ~address -> error 10.
REQ-028 Accepted frame: o_address = ext ? {address_bar,address} : {8'h00,address}; o_command = command.
REQ-029 o_valid pulses in the cycle after the stop-mark rising edge, and o_address/o_command update in that same cycle.
REQ-030 o_address/o_command hold their values on error and on repeat.
REQ-031 A completed repeat code pulses o_repeat only when a frame was accepted since reset; otherwise it is silently dropped, with no error.
REQ-032 o_valid, o_repeat and o_error are mutually exclusive in every cycle.

Reset
REQ-033 rst_n low at a clk edge: state IDLE, counter 0, shift register 0, all outputs 0, synchroniser flops 1, frame-seen flag cleared; this applies mid-frame.

Configuration
REQ-034 With NEC_RX_GLITCH_FILTER_EN defined, the synchronised input updates only after GLITCH_TICKS consecutive equal samples, adding GLITCH_TICKS cycles to edge latency.
REQ-035 Without NEC_RX_GLITCH_FILTER_EN, only the 2-flop synchroniser is present; GLITCH_TICKS is unused.

Structure
REQ-036 Package nec_pkg holds the state enum, error-code constants and the nominal durations (9000, 4500, 2250, 562, 1687 us).
REQ-037 Sub-module nec_in_conditioner (synchroniser, optional glitch filter, rise/fall strobes) is instantiated once.

Verification (FREQ_MHz=1, TOL_PCT=20)
REQ-038 Frame addr 0x2E/0xD1, cmd 0x0D/0xF2, ext=0 -> single o_valid, o_address=0x002E, o_command=0x0D, no o_error.
REQ-039 Bytes 0x16,0x17,0x19,0xE6 with ext=1 -> o_address=0x1716, o_command=0x19; same frame with ext=0 -> o_error, code 10, outputs unchanged.
REQ-040 After REQ-038, 9000/2250/562 repeat -> o_repeat pulse, o_address stays 0x002E; the same repeat right after reset -> no pulse, no error.
REQ-041 Lead mark 6000 us -> error 01; input held high 13 ms after bit 10 -> error 11; a following good frame decodes.
REQ-042 rst_n asserted for 1 cycle at bit 16 -> outputs 0 next cycle; the next full frame decodes correctly.
REQ-043 With macro: a 2-cycle low glitch inside a 1687 us space is ignored and the frame is accepted; without macro: the same glitch -> error 01.
